mod_n_updown_counter: RTL and testbench
=======================================

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port clr  input  1  synchronous clear to 0.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port d  input  WIDTH  parallel load value.
REQ-010 SHALL have port q  output  WIDTH  registered count value.
REQ-011 SHALL have port tc  output  1  combinational terminal-count/carry-out for cascading.
REQ-012 SHALL have port wrap  output  1  registered one-cycle wrap-event pulse.

Function
REQ-013 SHALL apply per-edge priority: clr > load > en > hold.
REQ-014 SHALL, with clr=1, set q=0 on the next edge regardless of other inputs.
REQ-015 SHALL, with load=1 and clr=0, set q=d if d<MODULUS, else q=MODULUS-1 (clamp).
REQ-016 SHALL, with en=1, up_dn=1, no clr/load, set q=q+1, or q=0 when q==MODULUS-1.
REQ-017 SHALL, with en=1, up_dn=0, no clr/load, set q=q-1, or q=MODULUS-1 when q==0.
REQ-018 SHALL hold q when en=0, clr=0, load=0.
REQ-019 SHALL drive tc=1 iff en=1, clr=0, load=0, and (up_dn=1 and q==MODULUS-1, or up_dn=0 and q==0); zero latency.
REQ-020 SHALL set wrap=1 for exactly the one cycle following an edge where tc was 1; otherwise 0.
REQ-021 SHALL never produce q>=MODULUS from any input sequence after reset.
REQ-022 SHALL take up_dn changes into effect on the very next enabled edge (no pipeline delay).
REQ-023 SHALL, for MODULUS==2**WIDTH, behave as a plain binary wrap-around counter.

Reset
REQ-024 SHALL, on reset_n=0, immediately force q=0 and wrap=0 independent of clk.
REQ-025 SHALL hold q=0, wrap=0 while reset_n=0; tc follows REQ-019 with q=0.
REQ-026 SHALL resume normal operation on the first rising clk edge after reset_n deasserts, including reset asserted mid-count.

Configuration
REQ-027 SHALL honour macro MOD_COUNTER_LOAD_EN: defined -> load and d function per REQ-015.
REQ-028 SHALL, without MOD_COUNTER_LOAD_EN, ignore load and d entirely (treated as load=0); ports remain present.

Verification
REQ-029 WIDTH=4, MODULUS=10, reset then en=1 up_dn=1 for 12 edges -> q 1..9,0,1,2; tc=1 while q=9; wrap=1 the cycle q=0.
REQ-030 MODULUS=10, q=0, en=1 up_dn=0 -> next q=9, tc=1 before edge, wrap=1 after.
REQ-031 Macro defined, load=1 d=7 -> q=7; load=1 d=12 -> q=9; clr=1 with load=1 d=5 -> q=0.
REQ-032 q=6 counting, reset_n pulsed low 3 ns between edges -> q=0, wrap=0 at once; counting resumes 1 at next edge after release.
REQ-033 Macro undefined, load=1 d=3 en=1 up from q=4 -> q=5 (load ignored).
REQ-034 WIDTH=4, MODULUS=16, en=0 for 5 edges at q=15 -> q stays 15, tc=0, wrap=0; en=1 -> q=0, wrap=1.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_n_updown_counter
//
// Modulo-N up/down counter with synchronous clear, optional parallel load,
// a combinational terminal-count output for cascading and a registered
// one-cycle wrap pulse.
//
// Count range is 0..MODULUS-1. Per-edge priority is clr > load > en > hold.
//
// Build option:
//   MOD_COUNTER_LOAD_EN - when defined, `load`/`d` perform a clamped
//                         parallel load. When undefined, both ports stay on
//                         the interface but are ignored (load treated as 0).
// -----------------------------------------------------------------------------
module mod_n_updown_counter #(
  parameter int     WIDTH   = 4,   // counter width, 2..32
  parameter longint MODULUS = 16   // count modulus, 2..2**WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Highest legal count value; the up direction wraps from here to zero.
  localparam logic [WIDTH-1:0] LP_MAX_VAL = WIDTH'(MODULUS - 1);

  // Modulus held one bit wider so MODULUS == 2**WIDTH is representable and
  // the load clamp compare degenerates to "always in range".
  localparam logic [WIDTH:0]   LP_MOD_EXT = (WIDTH + 1)'(MODULUS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             w_load_eff;   // load strobe after build-option gating
  logic [WIDTH-1:0] w_load_val;   // clamped load value
  logic             w_at_max;     // count sits at MODULUS-1
  logic             w_at_min;     // count sits at 0
  logic             w_count;      // this edge is an enabled count step
  logic [WIDTH-1:0] w_inc;        // modulo increment of current count
  logic [WIDTH-1:0] w_dec;        // modulo decrement of current count
  logic [WIDTH-1:0] w_q_next;     // value registered on the next edge

`ifdef MOD_COUNTER_LOAD_EN
  // Out-of-range load values saturate at the top of the range so the count
  // can never leave 0..MODULUS-1.
  assign w_load_eff = load;
  assign w_load_val = ({1'b0, d} < LP_MOD_EXT) ? d : LP_MAX_VAL;
`else
  // Load path compiled out: the ports remain but carry no function.
  logic w_unused_load;
  assign w_load_eff    = 1'b0;
  assign w_load_val    = '0;
  assign w_unused_load = ^{load, d};
`endif

  assign w_at_max = (r_q == LP_MAX_VAL);
  assign w_at_min = (r_q == '0);

  // A count step only happens when nothing of higher priority claims the edge.
  assign w_count  = en & ~clr & ~w_load_eff;

  // Explicit wrap at the range ends; for a full binary modulus this matches
  // natural overflow, for shorter moduli it keeps the count in range.
  assign w_inc = w_at_max ? '0         : (r_q + WIDTH'(1));
  assign w_dec = w_at_min ? LP_MAX_VAL : (r_q - WIDTH'(1));

  // Terminal count is combinational so a cascaded stage can use it as its
  // enable on the same edge. Direction changes take effect immediately.
  assign tc = w_count & (up_dn ? w_at_max : w_at_min);

  // Next-count selection with clr > load > en > hold priority.
  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = '0;
    end else if (w_load_eff) begin
      w_q_next = w_load_val;
    end else if (en) begin
      w_q_next = up_dn ? w_inc : w_dec;
    end
  end

  // Count and wrap registers; reset clears both immediately, without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= tc;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_updown_counter
//
// Drives a MODULUS=10 and a MODULUS=16 instance (WIDTH=4) from shared inputs.
// Each step computes expected tc before the edge and pushes the expected
// post-edge q/wrap of both instances onto a scoreboard queue, which is popped
// and compared after the edge. Honours MOD_COUNTER_LOAD_EN like the design.
// -----------------------------------------------------------------------------
module tb_mod_n_updown_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] d;
  logic [3:0] q10, q16;
  logic       tc10, tc16;
  logic       wrap10, wrap16;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] q10;
    logic       w10;
    logic [3:0] q16;
    logic       w16;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [3:0] m_q10;
  logic [3:0] m_q16;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .d(d), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .d(d), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic load_active(input logic l);
`ifdef MOD_COUNTER_LOAD_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_tc(input logic [3:0] mq, input int mod,
                                input logic e, input logic u,
                                input logic c, input logic l);
    if (!e || c || load_active(l)) return 1'b0;
    if (u) return (int'(mq) == mod - 1);
    return (mq == 4'd0);
  endfunction

  function automatic logic [3:0] m_next(input logic [3:0] mq, input int mod,
                                        input logic e, input logic u,
                                        input logic c, input logic l,
                                        input logic [3:0] dv);
    if (c) return 4'd0;
    if (load_active(l)) return (int'(dv) < mod) ? dv : 4'(mod - 1);
    if (!e) return mq;
    if (u) return (int'(mq) == mod - 1) ? 4'd0 : 4'(mq + 4'd1);
    return (mq == 4'd0) ? 4'(mod - 1) : 4'(mq - 4'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clocked transaction: drive, check tc, push expectation, clock, pop.
  task automatic step(input logic e, input logic u, input logic c,
                      input logic l, input logic [3:0] dv, input string tag);
    exp_t item;
    exp_t got;
    en = e; up_dn = u; clr = c; load = l; d = dv;
    #1;
    item.w10 = m_tc(m_q10, 10, e, u, c, l);
    item.w16 = m_tc(m_q16, 16, e, u, c, l);
    check({tag, ":tc10"}, 32'(tc10), 32'(item.w10));
    check({tag, ":tc16"}, 32'(tc16), 32'(item.w16));
    item.q10 = m_next(m_q10, 10, e, u, c, l, dv);
    item.q16 = m_next(m_q16, 16, e, u, c, l, dv);
    sb.push_back(item);
    m_q10 = item.q10;
    m_q16 = item.q16;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ":q10"},   32'(q10),    32'(got.q10));
    check({tag, ":wrap10"}, 32'(wrap10), 32'(got.w10));
    check({tag, ":q16"},   32'(q16),    32'(got.q16));
    check({tag, ":wrap16"}, 32'(wrap16), 32'(got.w16));
    $display("step %-10s en=%b up=%b clr=%b load=%b d=%0d -> q10=%0d wrap10=%b q16=%0d wrap16=%b",
             tag, e, u, c, l, dv, q10, wrap10, q16, wrap16);
  endtask

  initial begin
    en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd0;
    reset_n = 1'b1;
    m_q10 = 4'd0;
    m_q16 = 4'd0;

    // Asynchronous reset before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst:q10",    32'(q10),    32'd0);
    check("rst:wrap10", 32'(wrap10), 32'd0);
    check("rst:q16",    32'(q16),    32'd0);
    check("rst:tc10",   32'(tc10),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold:q10", 32'(q10), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Up count over the mod-10 wrap: q 1..9,0,1,2
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up");

    // Down across zero: 1, 0, 9 (wrap)
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "down");

    // Direction flip on consecutive edges
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "flip_up");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "flip_dn");

    // Clear to 0, count up to 4, then load with en (ignored unless load built in)
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, "clr_load");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up4");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, "load_d3");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, "load_d7");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd12, "load_d12");

    // Hold at terminal values with en=0, then release
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, "clr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "to_max");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "wrap_max");

    // Count to 6, then pulse reset for 3 ns between edges
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up6");
    en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst:q10",    32'(q10),    32'd0);
    check("midrst:wrap10", 32'(wrap10), 32'd0);
    check("midrst:q16",    32'(q16),    32'd0);
    check("midrst:tc10",   32'(tc10),   32'd1);
    m_q10 = 4'd0;
    m_q16 = 4'd0;
    #2 reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "resume");

    // Randomised mix of all controls
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), "rand");
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
